// File: rtl/tl_rx_ecrc_stream_checker.sv
`default_nettype none
// ============================================================================
// Module      : tl_rx_ecrc_stream_checker
// Description : ECRC checker for the TL RX path. It takes any bus width that
//               is a whole number of DWs. It accepts SOP/EOP-framed TLP beats,
//               masks the PCIe variant bits and folds the valid DWs into a
//               CRC-32 (poly 04C11DB7). It compares the result with the
//               trailing digest and strobes the result one cycle after EOP.
//               A saturating error counter is also kept.
// Options     : TL_RX_ECRC_HDR_LOG_EN - adds a 128-bit log of the header of
//               the first TLP that fails the check.
// Revision    : 1.0 - initial release
// ============================================================================
module tl_rx_ecrc_stream_checker #(
  parameter int NUM_DW        = 8,
  parameter int LEN_WIDTH     = 3,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic                     i_sop,
  input  logic                     i_eop,
  input  logic [32*NUM_DW-1:0]     i_data,
  input  logic [LEN_WIDTH-1:0]     i_length,
  input  logic                     i_td,
  input  logic                     i_cfg_ecrc_chk_en,
  input  logic                     i_cnt_clr,
  output logic                     o_chk_valid,
  output logic                     o_ecrc_error,
  output logic                     o_checked,
  output logic                     o_proto_err,
`ifdef TL_RX_ECRC_HDR_LOG_EN
  output logic [127:0]             o_hdr_log,
  output logic                     o_hdr_log_valid,
`endif
  output logic [ERR_CNT_WIDTH-1:0] o_err_cnt
);

  localparam int          DATA_WIDTH = 32 * NUM_DW;
  localparam logic [31:0] C_POLY     = 32'h04C1_1DB7;
  localparam logic [31:0] C_SEED     = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [31:0]              r_lfsr;
  logic [31:0]              r_rcv;
  logic                     r_td;
  logic                     r_en;
  logic                     r_checked;
  logic                     r_proto_err;
  logic [ERR_CNT_WIDTH-1:0] r_err_cnt;

  logic                     w_accept;
  logic                     w_start;
  logic                     w_cont;
  logic                     w_td_eff;
  logic                     w_en_eff;
  int                       w_len_eff;
  int                       w_ndw;
  logic [DATA_WIDTH-1:0]    w_masked;
  logic [31:0]              w_lfsr_nxt;
  logic [31:0]              w_rcv_dw;
  logic                     w_proto;
  logic                     w_mismatch;

  // Fold the first ndw DWs of a beat into the CRC, MSB of DW0 first.
  function automatic logic [31:0] crc_fold(input logic [31:0]           seed,
                                           input logic [DATA_WIDTH-1:0] data,
                                           input int                    ndw);
    logic [31:0] c;
    logic        fb;
    c = seed;
    for (int d = 0; d < NUM_DW; d++) begin
      if (d < ndw) begin
        for (int b = 31; b >= 0; b--) begin
          fb = c[31] ^ data[DATA_WIDTH-32-32*d+b];
          c  = {c[30:0], 1'b0} ^ (fb ? C_POLY : 32'h0);
        end
      end
    end
    return c;
  endfunction

  // The transmitted digest is the inverted remainder with each byte bit-reversed.
  function automatic logic [31:0] crc_to_digest(input logic [31:0] crc);
    logic [31:0] inv;
    logic [31:0] r;
    inv = ~crc;
    r   = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 8; j++) begin
        r[8*i+j] = inv[8*i+7-j];
      end
    end
    return r;
  endfunction

  assign o_ready     = !i_rst && (r_state != ST_CHECK);
  assign w_accept    = i_valid && o_ready;
  assign o_proto_err = r_proto_err;
  assign o_err_cnt   = r_err_cnt;
  assign w_mismatch  = r_checked && (r_rcv != crc_to_digest(r_lfsr));

  // Beat datapath: length clamp, variant-bit mask, CRC fold and digest pick.
  always_comb begin
    w_start   = w_accept && i_sop;
    w_cont    = w_accept && !i_sop && (r_state == ST_ACCUM);
    w_td_eff  = i_sop ? i_td : r_td;
    w_en_eff  = i_sop ? i_cfg_ecrc_chk_en : r_en;
    w_len_eff = (int'(i_length) >= NUM_DW) ? NUM_DW - 1 : int'(i_length);
    // With a digest on this beat its last valid DW is not part of the CRC.
    w_ndw     = (i_eop && w_td_eff && w_en_eff) ? w_len_eff : w_len_eff + 1;
    w_masked  = i_data;
    if (i_sop) begin
      w_masked[DATA_WIDTH-8]  = 1'b1;  // DW0 bit 24, Type[0]
      w_masked[DATA_WIDTH-10] = 1'b1;  // DW0 bit 22, EP
    end
    w_lfsr_nxt = crc_fold(i_sop ? C_SEED : r_lfsr, w_masked, w_ndw);
    w_rcv_dw   = i_data[DATA_WIDTH-32-32*w_len_eff +: 32];
    w_proto    = w_accept && (((r_state == ST_IDLE) && !i_sop) ||
                              ((r_state == ST_ACCUM) && i_sop));
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode and the result outputs shown during CHECK.
  always_comb begin
    w_state_nxt  = r_state;
    o_chk_valid  = 1'b0;
    o_checked    = 1'b0;
    o_ecrc_error = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && i_sop) w_state_nxt = i_eop ? ST_CHECK : ST_ACCUM;
      end
      ST_ACCUM: begin
        if (w_accept && i_eop) w_state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        o_chk_valid  = 1'b1;
        o_checked    = r_checked;
        o_ecrc_error = w_mismatch;
        w_state_nxt  = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // CRC state, latched TD/enable, received digest and framing-error pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lfsr      <= C_SEED;
      r_rcv       <= '0;
      r_td        <= 1'b0;
      r_en        <= 1'b0;
      r_checked   <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_proto_err <= w_proto;
      if (w_start || w_cont) begin
        r_lfsr <= w_lfsr_nxt;
        if (w_start) begin
          r_td <= i_td;
          r_en <= i_cfg_ecrc_chk_en;
        end
        if (i_eop) begin
          r_rcv     <= w_rcv_dw;
          r_checked <= w_td_eff && w_en_eff;
        end
      end
    end
  end

  // Saturating mismatch counter; a clear beats a simultaneous increment.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_cnt_clr) begin
      r_err_cnt <= '0;
    end else if (o_chk_valid && o_ecrc_error && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

`ifdef TL_RX_ECRC_HDR_LOG_EN
  logic [127:0] r_hdr_cap;
  logic [127:0] w_hdr_cap_nxt;
  logic [2:0]   r_hdr_fill;
  logic [2:0]   w_hdr_fill_nxt;
  logic [127:0] r_hdr_log;
  logic         r_hdr_log_valid;
  int           w_hdr_base;

  // Collect the first four raw DWs of the TLP, spanning beats on narrow buses.
  always_comb begin
    w_hdr_cap_nxt  = r_hdr_cap;
    w_hdr_fill_nxt = r_hdr_fill;
    w_hdr_base     = 0;
    if (w_start || (w_cont && (r_hdr_fill < 3'd4))) begin
      w_hdr_base = w_start ? 0 : int'(r_hdr_fill);
      if (w_start) w_hdr_cap_nxt = '0;
      for (int k = 0; k < 4; k++) begin
        if ((k >= w_hdr_base) && ((k - w_hdr_base) < NUM_DW)) begin
          w_hdr_cap_nxt[96-32*k +: 32] = i_data[DATA_WIDTH-32-32*(k-w_hdr_base) +: 32];
        end
      end
      w_hdr_fill_nxt = ((w_hdr_base + NUM_DW) >= 4) ? 3'd4 : 3'(w_hdr_base + NUM_DW);
    end
  end

  // Commit the header of the first failing TLP; later failures leave it alone.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hdr_cap       <= '0;
      r_hdr_fill      <= '0;
      r_hdr_log       <= '0;
      r_hdr_log_valid <= 1'b0;
    end else begin
      r_hdr_cap  <= w_hdr_cap_nxt;
      r_hdr_fill <= w_hdr_fill_nxt;
      if (i_cnt_clr) begin
        r_hdr_log_valid <= 1'b0;
      end else if (o_chk_valid && o_ecrc_error && !r_hdr_log_valid) begin
        r_hdr_log       <= r_hdr_cap;
        r_hdr_log_valid <= 1'b1;
      end
    end
  end

  assign o_hdr_log       = r_hdr_log;
  assign o_hdr_log_valid = r_hdr_log_valid;
`else
  // Header log not built: no extra ports and no storage.
`endif

endmodule
`default_nettype wire

// File: doc/tl_rx_ecrc_stream_checker.md
Name: tl_rx_ecrc_stream_checker

Overview:
- Parametrised ECRC checker for the TL RX path. Generalises the single-width write-handler ECRC to any bus width in whole DWs.
- Takes full TLP beats over a valid/ready handshake with SOP/EOP framing. Applies PCIe variant-bit masking, computes the CRC-32 (poly 04C11DB7), extracts the trailing digest and reports pass/fail one cycle after the final beat.
- Keeps a saturating error counter. Sits between the RX buffer write port and the write/completion handlers.

Parameters:
- NUM_DW, 8, bus width in DWs (1..16); DATA_WIDTH = 32*NUM_DW.
- LEN_WIDTH, 3, width of i_length; must be >= clog2(NUM_DW).
- ERR_CNT_WIDTH, 16, width of the ECRC error counter.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_valid  in  1  beat valid.
- o_ready  out  1  checker can accept a beat.
- i_sop  in  1  first beat of TLP.
- i_eop  in  1  last beat of TLP.
- i_data  in  DATA_WIDTH  beat data; DW0 at [DATA_WIDTH-1 -: 32], MSB-first.
- i_length  in  LEN_WIDTH  number of valid DWs minus 1, left-aligned.
- i_td  in  1  TLP digest present; sampled on the SOP beat.
- i_cfg_ecrc_chk_en  in  1  check enable; sampled on the SOP beat.
- i_cnt_clr  in  1  clear error counter.
- o_chk_valid  out  1  one-cycle result strobe.
- o_ecrc_error  out  1  digest mismatch; qualified by o_chk_valid.
- o_checked  out  1  1 = CRC was compared; 0 = TD=0 or check disabled.
- o_proto_err  out  1  one-cycle framing violation pulse.
- o_err_cnt  out  ERR_CNT_WIDTH  saturating mismatch count.

Behaviour:
- Reset (i_rst high at a clock edge): state IDLE, LFSR = FFFF_FFFF, all outputs 0, o_ready = 0 during reset, o_err_cnt = 0. Reset mid-TLP aborts the TLP with no result strobe.
- Beat accepted when i_valid && o_ready.
- FSM states:
  - IDLE: o_ready=1. An accepted SOP latches td and en and goes to ACCUM, or to CHECK if i_eop is also set. An accepted non-SOP beat pulses o_proto_err and is dropped.
  - ACCUM: o_ready=1. Data beats fold into the LFSR. An accepted EOP goes to CHECK. An accepted SOP pulses o_proto_err, reseeds the LFSR and restarts with the new TLP.
  - CHECK: o_ready=0 for exactly one cycle. Drives o_chk_valid=1, o_checked and o_ecrc_error, then returns to IDLE. This gives one bubble per TLP.
- CRC rules:
  - Seed FFFF_FFFF at every SOP.
  - Bits are processed MSB-first across the valid DWs only (DW0..DW i_length).
  - On the SOP beat, DW0 bit 24 (Type[0]) and bit 22 (EP) are forced to 1 before folding.
  - Invalid DWs are ignored.
- Digest rules when td=1:
  - The last valid DW of the EOP beat is the received digest and is excluded from the CRC.
  - Expected digest = ~LFSR with each byte bit-reversed.
  - An EOP with i_length=0 carries the digest only.
- o_ecrc_error = checked && (rcv != expected).
- checked = td && en. When checked=0, o_ecrc_error is 0 and the whole EOP beat is data, never digest.
- Result latency: o_chk_valid asserts exactly one cycle after the EOP beat is accepted.
- Counter: increments on o_chk_valid && o_ecrc_error and saturates at all-ones. i_cnt_clr wins over a simultaneous increment.
- If i_length >= NUM_DW, it is treated as NUM_DW-1.

Optional Feature:
- Macro: TL_RX_ECRC_HDR_LOG_EN.
- When defined:
  - Adds output o_hdr_log (128 bits) and o_hdr_log_valid.
  - The first 4 DWs of the SOP beat are captured unmasked, DW0 at the MSB. If NUM_DW < 4, the remaining DWs come from following beats.
  - On the first ECRC error the captured header is committed to o_hdr_log and o_hdr_log_valid is set.
  - Further errors do not overwrite the log. i_cnt_clr clears o_hdr_log_valid.
- When undefined: no log ports and no log storage.

Test Plan:
- NUM_DW=8, 4DW MWr with 2 data DWs and correct digest, sent as a single SOP+EOP beat with i_length=6 -> o_chk_valid one cycle later, o_ecrc_error=0, o_checked=1, o_err_cnt=0.
- Same TLP with data DW1 bit 0 flipped -> o_ecrc_error=1, o_err_cnt=1. Also with only EP flipped in DW0 -> o_ecrc_error=0, since the masked bit does not affect the CRC.
- 3-beat TLP (i_length 7,7,0), where the EOP beat carries the digest only and the SOP beat has i_valid gaps -> result is correct, with o_ready=0 only in the CHECK cycle.
- td=0, or i_cfg_ecrc_chk_en=0 at SOP -> o_chk_valid=1, o_checked=0, o_ecrc_error=0 even with a garbage last DW.
- EOP while IDLE, and SOP while ACCUM -> o_proto_err pulses; the second TLP's result is correct.
- ERR_CNT_WIDTH=2, send 5 bad TLPs -> o_err_cnt saturates at 3. Assert i_cnt_clr together with a 6th bad result -> o_err_cnt=0. With i_rst high mid-ACCUM -> no strobe, and state is IDLE on the next cycle.
